// File: rtl/mem_stage.sv
// LA32R memory-access stage: holds one instruction, waits for load data on the
// data bus, aligns/extends it and forwards register/CSR results to write-back.
module mem_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        to_mem_valid,
   input  logic [31:0] es_pc,
   input  logic [3:0]  es_rf_we,
   input  logic [4:0]  es_rf_waddr,
   input  logic [31:0] es_alu_result,
   input  logic        es_mem_req,
   input  logic [4:0]  es_load_op,
   input  logic        es_csr_we,
   input  logic [13:0] es_csr_num,
   input  logic [31:0] es_csr_wdata,
   input  logic [4:0]  es_csr_wmask,
   input  logic [31:0] data_rdata,
   input  logic        data_data_ok,
   input  logic        wb_allow_in,
   output logic        mem_allow_in,
   output logic        mem_to_wb_valid,
   output logic [31:0] mem_pc,
   output logic [3:0]  mem_rf_we,
   output logic [4:0]  mem_rf_waddr,
   output logic [31:0] mem_rf_wdata,
   output logic        mem_csr_we,
   output logic [13:0] mem_csr_num,
   output logic [31:0] mem_csr_wdata,
   output logic [4:0]  mem_csr_wmask,
   output logic        mem_fwd_we,
   output logic [4:0]  mem_fwd_waddr,
   output logic [31:0] mem_fwd_wdata,
   output logic        mem_load_wait
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } resp_state_e;

   resp_state_e state_q, state_d;

   logic        mem_valid_q, mem_valid_d;
   logic [31:0] pc_q, pc_d;
   logic [3:0]  rf_we_q, rf_we_d;
   logic [4:0]  rf_waddr_q, rf_waddr_d;
   logic [31:0] alu_result_q, alu_result_d;
   logic        mem_req_q, mem_req_d;
   logic [4:0]  load_op_q, load_op_d;
   logic        csr_we_q, csr_we_d;
   logic [13:0] csr_num_q, csr_num_d;
   logic [31:0] csr_wdata_q, csr_wdata_d;
   logic [4:0]  csr_wmask_q, csr_wmask_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic        rbuf_valid_q, rbuf_valid_d;

   logic        data_ok_counted;
   logic        mem_ready_go;
   logic        leave;
   logic        new_req;
   logic        is_load;
   logic [31:0] ld_word;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] rf_wdata;

   // Handshake: a transfer happens on a cycle where the sender's valid and the
   // receiver's allow_in are both 1; valid never looks at the same-side allow_in.
   assign data_ok_counted = data_data_ok && (state_q == S_WAIT);
   assign mem_ready_go    = !mem_req_q || data_ok_counted || rbuf_valid_q;
   assign mem_allow_in    = !mem_valid_q || (mem_ready_go && wb_allow_in);
   assign mem_to_wb_valid = mem_valid_q && mem_ready_go && !flush;
   assign leave           = mem_to_wb_valid && wb_allow_in;
   assign new_req         = mem_allow_in && to_mem_valid && es_mem_req && !flush;
   assign is_load         = |load_op_q;

   always_comb begin
      mem_valid_d  = mem_valid_q;
      pc_d         = pc_q;
      rf_we_d      = rf_we_q;
      rf_waddr_d   = rf_waddr_q;
      alu_result_d = alu_result_q;
      mem_req_d    = mem_req_q;
      load_op_d    = load_op_q;
      csr_we_d     = csr_we_q;
      csr_num_d    = csr_num_q;
      csr_wdata_d  = csr_wdata_q;
      csr_wmask_d  = csr_wmask_q;
      if (mem_allow_in) begin
         mem_valid_d  = to_mem_valid;
         pc_d         = es_pc;
         rf_we_d      = es_rf_we;
         rf_waddr_d   = es_rf_waddr;
         alu_result_d = es_alu_result;
         mem_req_d    = es_mem_req;
         load_op_d    = es_load_op;
         csr_we_d     = es_csr_we;
         csr_num_d    = es_csr_num;
         csr_wdata_d  = es_csr_wdata;
         csr_wmask_d  = es_csr_wmask;
      end
      if (flush) begin
         mem_valid_d = 1'b0;
      end
   end

   // DISCARD owes the bus one stale response; a request held behind it waits
   // for the response after that one.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (new_req) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flush) begin
               state_d = data_data_ok ? S_IDLE : S_DISCARD;
            end else if (data_data_ok) begin
               state_d = new_req ? S_WAIT : S_IDLE;
            end
         end
         S_DISCARD: begin
            if (data_data_ok) begin
               if (mem_valid_q && mem_req_q) begin
                  state_d = flush ? S_DISCARD : S_WAIT;
               end else begin
                  state_d = new_req ? S_WAIT : S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rbuf_d       = rbuf_q;
      rbuf_valid_d = rbuf_valid_q;
      if (leave || flush) begin
         rbuf_valid_d = 1'b0;
      end
      if (data_ok_counted && !wb_allow_in && !flush) begin
         rbuf_d       = data_rdata;
         rbuf_valid_d = 1'b1;
      end
   end

   // Buffered data takes priority: once captured, the bus may already carry
   // an unrelated response.
   always_comb begin
      ld_word = rbuf_valid_q ? rbuf_q : data_rdata;
      ld_byte = ld_word[7:0];
      case (alu_result_q[1:0])
         2'd0: ld_byte = ld_word[7:0];
         2'd1: ld_byte = ld_word[15:8];
         2'd2: ld_byte = ld_word[23:16];
         2'd3: ld_byte = ld_word[31:24];
         default: ld_byte = ld_word[7:0];
      endcase
      ld_half  = alu_result_q[1] ? ld_word[31:16] : ld_word[15:0];
      rf_wdata = alu_result_q;
      if (load_op_q[0]) begin
         rf_wdata = {{24{ld_byte[7]}}, ld_byte};
      end else if (load_op_q[1]) begin
         rf_wdata = {{16{ld_half[15]}}, ld_half};
      end else if (load_op_q[2]) begin
         rf_wdata = ld_word;
      end else if (load_op_q[3]) begin
         rf_wdata = {24'd0, ld_byte};
      end else if (load_op_q[4]) begin
         rf_wdata = {16'd0, ld_half};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         mem_valid_q  <= 1'b0;
         pc_q         <= 32'd0;
         rf_we_q      <= 4'd0;
         rf_waddr_q   <= 5'd0;
         alu_result_q <= 32'd0;
         mem_req_q    <= 1'b0;
         load_op_q    <= 5'd0;
         csr_we_q     <= 1'b0;
         csr_num_q    <= 14'd0;
         csr_wdata_q  <= 32'd0;
         csr_wmask_q  <= 5'd0;
         rbuf_q       <= 32'd0;
         rbuf_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_valid_q  <= mem_valid_d;
         pc_q         <= pc_d;
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         alu_result_q <= alu_result_d;
         mem_req_q    <= mem_req_d;
         load_op_q    <= load_op_d;
         csr_we_q     <= csr_we_d;
         csr_num_q    <= csr_num_d;
         csr_wdata_q  <= csr_wdata_d;
         csr_wmask_q  <= csr_wmask_d;
         rbuf_q       <= rbuf_d;
         rbuf_valid_q <= rbuf_valid_d;
      end
   end

   assign mem_pc        = pc_q;
   assign mem_rf_we     = rf_we_q & {4{mem_valid_q}};
   assign mem_rf_waddr  = rf_waddr_q;
   assign mem_rf_wdata  = rf_wdata;
   assign mem_csr_we    = csr_we_q & mem_valid_q;
   assign mem_csr_num   = csr_num_q;
   assign mem_csr_wdata = csr_wdata_q;
   assign mem_csr_wmask = csr_wmask_q;

   assign mem_fwd_we    = mem_valid_q && (|rf_we_q) && mem_ready_go;
   assign mem_fwd_waddr = rf_waddr_q;
   assign mem_fwd_wdata = rf_wdata;
   assign mem_load_wait = mem_valid_q && is_load && !mem_ready_go;

endmodule
